bolme_birimi: RTL and testbench

//  Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU in the execute stage.

---
 rtl/bolme_birimi_if.sv | 21 ++
 rtl/bolme_birimi.sv | 129 ++++++++++++
 tb/tb_bolme_birimi.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bolme_birimi_if.sv
// Request/response bundle between the execute stage and the iterative divider.
interface bolme_birimi_if;
  logic        basla_i;
  logic        iptal_i;
  logic [1:0]  islem_i;
  logic [31:0] bolunen_i;
  logic [31:0] bolen_i;
  logic        mesgul_o;
  logic        bitti_o;
  logic [31:0] sonuc_o;

  modport master (
    output basla_i, iptal_i, islem_i, bolunen_i, bolen_i,
    input  mesgul_o, bitti_o, sonuc_o
  );

  modport slave (
    input  basla_i, iptal_i, islem_i, bolunen_i, bolen_i,
    output mesgul_o, bitti_o, sonuc_o
  );
endinterface

// File: rtl/bolme_birimi.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Leading zeros of |dividend| are skipped so short operands finish early.
module zero_counter (
  input  logic [31:0] deger,
  output logic [5:0]  sayi
);
  always_comb begin
    sayi = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (deger[i]) sayi = 6'(31 - i);
    end
  end
endmodule

module bolme_birimi #(
  parameter bit ERKEN_CIKIS = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bolme_birimi_if.slave bus
);
  typedef enum logic [1:0] {BOSTA, HAZIRLA, BOL, SONUC} durum_t;

  durum_t      durum;
  logic [1:0]  islem;
  logic [31:0] a, b, dvd, bmag, q, rem;
  logic [5:0]  sayac;

  logic        isaretli, kalan_mi, neg_q, neg_r, tasma, ozel_mi, buyuk, kabul;
  logic [31:0] abs_a, abs_b, ilk_dvd, rem_yeni, q_yeni, bitis_sonuc, ozel_sonuc;
  logic [5:0]  clz, adim;
  logic [32:0] rem_kay;

  zero_counter u_zero_counter (.deger(abs_a), .sayi(clz));

  always_comb begin
    isaretli = ~islem[0];
    kalan_mi = islem[1];
    abs_a    = (isaretli && a[31]) ? -a : a;
    abs_b    = (isaretli && b[31]) ? -b : b;
    neg_q    = isaretli & (a[31] ^ b[31]);
    neg_r    = isaretli & a[31];
    adim     = ERKEN_CIKIS ? (6'd32 - clz) : 6'd32;
    ilk_dvd  = ERKEN_CIKIS ? (abs_a << clz) : abs_a;
    tasma    = isaretli && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ozel_mi  = (b == 32'd0) || tasma || (adim == 6'd0);

    // Divide-by-zero and signed overflow results follow the RISC-V definitions.
    if (b == 32'd0)
      ozel_sonuc = kalan_mi ? a : 32'hFFFF_FFFF;
    else if (tasma)
      ozel_sonuc = kalan_mi ? 32'd0 : 32'h8000_0000;
    else
      ozel_sonuc = 32'd0;

    rem_kay     = {rem, dvd[31]};
    buyuk       = rem_kay >= {1'b0, bmag};
    rem_yeni    = buyuk ? (rem_kay[31:0] - bmag) : rem_kay[31:0];
    q_yeni      = {q[30:0], buyuk};
    bitis_sonuc = kalan_mi ? (neg_r ? -rem_yeni : rem_yeni)
                           : (neg_q ? -q_yeni : q_yeni);
    kabul       = bus.basla_i & ~bus.mesgul_o & ~bus.iptal_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum        <= BOSTA;
      islem        <= 2'd0;
      a            <= 32'd0;
      b            <= 32'd0;
      dvd          <= 32'd0;
      bmag         <= 32'd0;
      q            <= 32'd0;
      rem          <= 32'd0;
      sayac        <= 6'd0;
      bus.mesgul_o <= 1'b0;
      bus.bitti_o  <= 1'b0;
      bus.sonuc_o  <= 32'd0;
    end else if (bus.iptal_i) begin
      durum        <= BOSTA;
      bus.mesgul_o <= 1'b0;
      bus.bitti_o  <= 1'b0;
    end else begin
      case (durum)
        BOSTA, SONUC: begin
          bus.bitti_o <= 1'b0;
          if (kabul) begin
            islem        <= bus.islem_i;
            a            <= bus.bolunen_i;
            b            <= bus.bolen_i;
            bus.mesgul_o <= 1'b1;
            durum        <= HAZIRLA;
          end else begin
            durum <= BOSTA;
          end
        end
        HAZIRLA: begin
          if (ozel_mi) begin
            bus.sonuc_o  <= ozel_sonuc;
            bus.bitti_o  <= 1'b1;
            bus.mesgul_o <= 1'b0;
            durum        <= SONUC;
          end else begin
            dvd   <= ilk_dvd;
            rem   <= 32'd0;
            q     <= 32'd0;
            bmag  <= abs_b;
            sayac <= adim;
            durum <= BOL;
          end
        end
        BOL: begin
          dvd   <= dvd << 1;
          rem   <= rem_yeni;
          q     <= q_yeni;
          sayac <= sayac - 6'd1;
          // The final quotient bit is folded in here so the result is ready in SONUC.
          if (sayac == 6'd1) begin
            bus.sonuc_o  <= bitis_sonuc;
            bus.bitti_o  <= 1'b1;
            bus.mesgul_o <= 1'b0;
            durum        <= SONUC;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end
endmodule

// File: tb/tb_bolme_birimi.sv
// Directed self-checking bench for bolme_birimi (early-exit and fixed-32 variants).
module tb_bolme_birimi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  bolme_birimi_if bus();
  bolme_birimi_if bus2();

  bolme_birimi #(.ERKEN_CIKIS(1'b1)) dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
  bolme_birimi #(.ERKEN_CIKIS(1'b0)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

  always #5 clk = ~clk;

  // Accepts one operation on the early-exit unit and waits for bitti_o (lat=-1 on timeout).
  task automatic do_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] res, output logic busy1);
    bus.islem_i = op; bus.bolunen_i = x; bus.bolen_i = y; bus.basla_i = 1'b1;
    @(posedge clk); #1;
    bus.basla_i = 1'b0;
    busy1 = bus.mesgul_o;
    lat = 1;
    while (bus.bitti_o !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.bitti_o !== 1'b1) lat = -1;
    res = bus.sonuc_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.mesgul_o !== 1'b0) begin failures++; $display("FAIL reset_mesgul got=%b exp=0", bus.mesgul_o); end
    checks++; if (bus.bitti_o !== 1'b0) begin failures++; $display("FAIL reset_bitti got=%b exp=0", bus.bitti_o); end
    checks++; if (bus.sonuc_o !== 32'd0) begin failures++; $display("FAIL reset_sonuc got=%h exp=0", bus.sonuc_o); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int lat; logic [31:0] res; logic busy1;
    do_op(2'b01, 32'd100, 32'd7, lat, res, busy1);
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL divu_busy got=%b exp=1", busy1); end
    checks++; if (lat !== 9) begin failures++; $display("FAIL divu_lat got=%0d exp=9", lat); end
    checks++; if (res !== 32'd14) begin failures++; $display("FAIL divu_res got=%h exp=%h", res, 32'd14); end
    checks++; if (bus.mesgul_o !== 1'b0) begin failures++; $display("FAIL divu_busy_done got=%b exp=0", bus.mesgul_o); end
    @(posedge clk); #1;
    checks++; if (bus.bitti_o !== 1'b0) begin failures++; $display("FAIL bitti_pulse got=%b exp=0", bus.bitti_o); end
    checks++; if (bus.sonuc_o !== 32'd14) begin failures++; $display("FAIL sonuc_hold got=%h exp=%h", bus.sonuc_o, 32'd14); end
    do_op(2'b11, 32'd100, 32'd7, lat, res, busy1);
    checks++; if (lat !== 9 || res !== 32'd2) begin failures++; $display("FAIL remu got=%h lat=%0d exp=2 lat=9", res, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    int lat; logic [31:0] res; logic busy1;
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, lat, res, busy1);
    checks++; if (lat !== 5 || res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg got=%h lat=%0d exp=fffffffd lat=5", res, lat); end
    @(posedge clk); #1;
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, res, busy1);
    checks++; if (lat !== 5 || res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_neg got=%h lat=%0d exp=ffffffff lat=5", res, lat); end
    @(posedge clk); #1;
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, lat, res, busy1);
    checks++; if (lat !== 5 || res !== 32'd1) begin failures++; $display("FAIL rem_negdiv got=%h lat=%0d exp=1 lat=5", res, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_special();
    int lat; logic [31:0] res; logic busy1;
    logic [1:0]  ops  [7] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01};
    logic [31:0] as   [7] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'd0};
    logic [31:0] bs   [7] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd5};
    logic [31:0] exps [7] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd0};
    for (int i = 0; i < 7; i++) begin
      do_op(ops[i], as[i], bs[i], lat, res, busy1);
      checks++; if (lat !== 2 || res !== exps[i]) begin failures++; $display("FAIL special_%0d got=%h lat=%0d exp=%h lat=2", i, res, lat, exps[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_max_latency();
    int lat; logic [31:0] res; logic busy1;
    do_op(2'b01, 32'hFFFF_FFFF, 32'd1, lat, res, busy1);
    checks++; if (lat !== 34 || res !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_max got=%h lat=%0d exp=ffffffff lat=34", res, lat); end
    @(posedge clk); #1;
    do_op(2'b00, 32'h8000_0000, 32'd1, lat, res, busy1);
    checks++; if (lat !== 34 || res !== 32'h8000_0000) begin failures++; $display("FAIL div_minint got=%h lat=%0d exp=80000000 lat=34", res, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_no_early_exit();
    int lat;
    bus2.islem_i = 2'b01; bus2.bolunen_i = 32'd1; bus2.bolen_i = 32'd1; bus2.basla_i = 1'b1;
    @(posedge clk); #1;
    bus2.basla_i = 1'b0;
    lat = 1;
    while (bus2.bitti_o !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus2.bitti_o !== 1'b1) lat = -1;
    checks++; if (lat !== 34 || bus2.sonuc_o !== 32'd1) begin failures++; $display("FAIL fixed32 got=%h lat=%0d exp=1 lat=34", bus2.sonuc_o, lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int lat; logic [31:0] res; logic busy1; logic seen;
    do_op(2'b11, 32'd100, 32'd7, lat, res, busy1);
    @(posedge clk); #1;
    bus.islem_i = 2'b01; bus.bolunen_i = 32'hFFFF_0000; bus.bolen_i = 32'd3; bus.basla_i = 1'b1;
    @(posedge clk); #1;
    bus.basla_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    bus.iptal_i = 1'b1;
    @(posedge clk); #1;
    bus.iptal_i = 1'b0;
    checks++; if (bus.mesgul_o !== 1'b0) begin failures++; $display("FAIL abort_mesgul got=%b exp=0", bus.mesgul_o); end
    seen = 1'b0;
    repeat (40) begin
      if (bus.bitti_o === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_bitti got=%b exp=0", seen); end
    checks++; if (bus.sonuc_o !== 32'd2) begin failures++; $display("FAIL abort_sonuc got=%h exp=2", bus.sonuc_o); end
    do_op(2'b01, 32'd100, 32'd7, lat, res, busy1);
    checks++; if (lat !== 9 || res !== 32'd14) begin failures++; $display("FAIL after_abort got=%h lat=%0d exp=e lat=9", res, lat); end
    // Still in the bitti_o cycle: a start with flush in the same cycle must be dropped.
    bus.basla_i = 1'b1; bus.iptal_i = 1'b1;
    @(posedge clk); #1;
    bus.basla_i = 1'b0; bus.iptal_i = 1'b0;
    checks++; if (bus.mesgul_o !== 1'b0 || bus.bitti_o !== 1'b0) begin failures++; $display("FAIL sonuc_iptal got=%b%b exp=00", bus.mesgul_o, bus.bitti_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] res; logic busy1; logic extra;
    do_op(2'b01, 32'd100, 32'd7, lat, res, busy1);
    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, lat, res, busy1);
    checks++; if (busy1 !== 1'b1 || lat !== 5 || res !== 32'hFFFF_FFFD) begin failures++; $display("FAIL b2b got=%h lat=%0d busy=%b exp=fffffffd lat=5 busy=1", res, lat, busy1); end
    @(posedge clk); #1;
    bus.islem_i = 2'b01; bus.bolunen_i = 32'd100; bus.bolen_i = 32'd7; bus.basla_i = 1'b1;
    @(posedge clk); #1;
    bus.basla_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.basla_i = 1'b1; bus.islem_i = 2'b11; bus.bolunen_i = 32'd50; bus.bolen_i = 32'd5;
    @(posedge clk); #1;
    bus.basla_i = 1'b0;
    lat = 4;
    while (bus.bitti_o !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.bitti_o !== 1'b1) lat = -1;
    checks++; if (lat !== 9 || bus.sonuc_o !== 32'd14) begin failures++; $display("FAIL busy_ignore got=%h lat=%0d exp=e lat=9", bus.sonuc_o, lat); end
    extra = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.bitti_o === 1'b1 || bus.mesgul_o === 1'b1) extra = 1'b1;
    end
    checks++; if (extra !== 1'b0) begin failures++; $display("FAIL busy_ignore_extra got=%b exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; logic busy1;
    bus.islem_i = 2'b01; bus.bolunen_i = 32'hFFFF_FFFF; bus.bolen_i = 32'd1; bus.basla_i = 1'b1;
    @(posedge clk); #1;
    bus.basla_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.mesgul_o !== 1'b0 || bus.bitti_o !== 1'b0 || bus.sonuc_o !== 32'd0) begin failures++; $display("FAIL reset_mid got=%b%b %h exp=00 0", bus.mesgul_o, bus.bitti_o, bus.sonuc_o); end
    do_op(2'b01, 32'd100, 32'd7, lat, res, busy1);
    checks++; if (lat !== 9 || res !== 32'd14) begin failures++; $display("FAIL after_reset got=%h lat=%0d exp=e lat=9", res, lat); end
  endtask

  initial begin
    bus.basla_i = 1'b0; bus.iptal_i = 1'b0; bus.islem_i = 2'b00; bus.bolunen_i = 32'd0; bus.bolen_i = 32'd0;
    bus2.basla_i = 1'b0; bus2.iptal_i = 1'b0; bus2.islem_i = 2'b00; bus2.bolunen_i = 32'd0; bus2.bolen_i = 32'd0;
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_max_latency();
    test_no_early_exit();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
